// File: rtl/t05_codebook_sram_arbiter.sv
// Two-requester round-robin arbiter for the shared 128-bit codebook SRAM port.
// One transaction in flight; a stalled memory is released by a timeout error ack.
module t05_codebook_sram_arbiter #(
  parameter int ADDR_W  = 8,
  parameter int DATA_W  = 128,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic              r0_req,
  input  logic              r0_we,
  input  logic [ADDR_W-1:0] r0_addr,
  input  logic [DATA_W-1:0] r0_wdata,
  input  logic              r1_req,
  input  logic              r1_we,
  input  logic [ADDR_W-1:0] r1_addr,
  input  logic [DATA_W-1:0] r1_wdata,
  output logic              r0_ack,
  output logic              r0_err,
  output logic [DATA_W-1:0] r0_rdata,
  output logic              r1_ack,
  output logic              r1_err,
  output logic [DATA_W-1:0] r1_rdata,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy,
  output logic              grant_id
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t           state, state_nxt;
  logic             last_grant;
  logic [CNT_W-1:0] cnt;
  logic             do_grant, win, done_ok, done_to;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // On a tie the requester that did not win last time is served.
  always_comb begin
    state_nxt = state;
    do_grant  = 1'b0;
    win       = 1'b0;
    done_ok   = 1'b0;
    done_to   = 1'b0;
    case (state)
      IDLE: begin
        if (enable && (r0_req || r1_req)) begin
          do_grant  = 1'b1;
          win       = (r0_req && r1_req) ? ~last_grant : r1_req;
          state_nxt = WAIT;
        end
      end
      WAIT: begin
        if (mem_ack) begin
          done_ok   = 1'b1;
          state_nxt = RESP;
        end else if (cnt == CNT_W'(TIMEOUT - 1)) begin
          done_to   = 1'b1;
          state_nxt = RESP;
        end
      end
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign mem_req = (state == WAIT);
  assign busy    = (state != IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      grant_id   <= 1'b0;
      last_grant <= 1'b1;
      cnt        <= '0;
      r0_ack     <= 1'b0;
      r0_err     <= 1'b0;
      r0_rdata   <= '0;
      r1_ack     <= 1'b0;
      r1_err     <= 1'b0;
      r1_rdata   <= '0;
    end else begin
      if (do_grant) begin
        mem_we     <= win ? r1_we    : r0_we;
        mem_addr   <= win ? r1_addr  : r0_addr;
        mem_wdata  <= win ? r1_wdata : r0_wdata;
        grant_id   <= win;
        last_grant <= win;
        cnt        <= '0;
      end else if (state == WAIT && !mem_ack) begin
        cnt <= cnt + CNT_W'(1);
      end
      // Response registers are rewritten every cycle so they fall back to 0 after the pulse.
      r0_ack   <= (done_ok | done_to) & ~grant_id;
      r0_err   <= done_to & ~grant_id;
      r0_rdata <= (done_ok & ~grant_id) ? mem_rdata : '0;
      r1_ack   <= (done_ok | done_to) & grant_id;
      r1_err   <= done_to & grant_id;
      r1_rdata <= (done_ok & grant_id) ? mem_rdata : '0;
    end
  end

endmodule

// File: tb/tb_t05_codebook_sram_arbiter.sv
// Bench for t05_codebook_sram_arbiter: directed steps then random transactions
// checked against a transaction-level arbiter model and a behavioural SRAM.
module tb_t05_codebook_sram_arbiter;

  localparam int AW = 8;
  localparam int DW = 128;
  localparam int TO = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          enable = 1'b1;
  logic          r0_req = 1'b0, r0_we = 1'b0, r1_req = 1'b0, r1_we = 1'b0;
  logic [AW-1:0] r0_addr = '0, r1_addr = '0;
  logic [DW-1:0] r0_wdata = '0, r1_wdata = '0;
  logic          r0_ack, r0_err, r1_ack, r1_err;
  logic [DW-1:0] r0_rdata, r1_rdata;
  logic          mem_req, mem_we, mem_ack = 1'b0;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata = '0;
  logic          busy, grant_id;

  int  n_assert = 0;
  int  n_fail   = 0;
  int  cyc      = 0;
  int  ack_cyc  = 0;
  int  prev_ack = 0;
  bit  model_last = 1'b1;
  logic [DW-1:0] sram [256];

  t05_codebook_sram_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .enable(enable),
    .r0_req(r0_req), .r0_we(r0_we), .r0_addr(r0_addr), .r0_wdata(r0_wdata),
    .r1_req(r1_req), .r1_we(r1_we), .r1_addr(r1_addr), .r1_wdata(r1_wdata),
    .r0_ack(r0_ack), .r0_err(r0_err), .r0_rdata(r0_rdata),
    .r1_ack(r1_ack), .r1_err(r1_err), .r1_rdata(r1_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata), .busy(busy), .grant_id(grant_id)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_mem_req"}, mem_req, 0);
    chk({tag, "_mem_we"}, mem_we, 0);
    chk({tag, "_mem_addr"}, mem_addr, 0);
    chk({tag, "_mem_wdata"}, mem_wdata, 0);
    chk({tag, "_acks"}, {r0_ack, r1_ack}, 0);
    chk({tag, "_errs"}, {r0_err, r1_err}, 0);
    chk({tag, "_r0_rdata"}, r0_rdata, 0);
    chk({tag, "_r1_rdata"}, r1_rdata, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_grant_id"}, grant_id, 0);
  endtask

  // Called at the falling edge of an IDLE cycle with requests applied (cycle 0).
  // lat = cycle in which mem_ack is given (0 or >TO means never). Returns at the next IDLE.
  task automatic run_txn(input string tag, input int lat, input bit keep, input bit drop_en);
    bit            win;
    bit            we;
    bit            got;
    int            c;
    logic [AW-1:0] addr;
    logic [DW-1:0] wd, rd;
    win  = (r0_req && r1_req) ? ~model_last : r1_req;
    we   = win ? r1_we : r0_we;
    addr = win ? r1_addr : r0_addr;
    wd   = win ? r1_wdata : r0_wdata;
    rd   = '0;
    got  = 1'b0;
    model_last = win;
    @(negedge clk);
    if (drop_en) enable = 1'b0;
    for (c = 1; c <= TO; c++) begin
      chk({tag, "_mem_req"}, mem_req, 1);
      chk({tag, "_busy"}, busy, 1);
      chk({tag, "_grant_id"}, grant_id, win);
      chk({tag, "_mem_we"}, mem_we, we);
      chk({tag, "_mem_addr"}, mem_addr, addr);
      chk({tag, "_mem_wdata"}, mem_wdata, wd);
      chk({tag, "_early_ack"}, {r0_ack, r1_ack}, 0);
      if (c == lat) begin
        mem_ack   = 1'b1;
        rd        = we ? {$urandom, $urandom, $urandom, $urandom} : sram[addr];
        mem_rdata = rd;
        got       = 1'b1;
      end else begin
        mem_ack   = 1'b0;
        mem_rdata = {$urandom, $urandom, $urandom, $urandom};
      end
      @(negedge clk);
      if (got) break;
    end
    // Response cycle.
    ack_cyc = cyc;
    mem_ack = 1'($urandom_range(0, 1));
    chk({tag, "_ack_win"}, win ? r1_ack : r0_ack, 1);
    chk({tag, "_ack_other"}, win ? r0_ack : r1_ack, 0);
    chk({tag, "_err_win"}, win ? r1_err : r0_err, !got);
    chk({tag, "_err_other"}, win ? r0_err : r1_err, 0);
    if (!(got && we)) chk({tag, "_rdata_win"}, win ? r1_rdata : r0_rdata, got ? rd : '0);
    chk({tag, "_rdata_other"}, win ? r0_rdata : r1_rdata, 0);
    chk({tag, "_resp_mem_req"}, mem_req, 0);
    if (got && we) sram[addr] = wd;
    if (!keep) begin
      if (win) r1_req = 1'b0;
      else     r0_req = 1'b0;
    end
    @(negedge clk);
    mem_ack = 1'b0;
    chk({tag, "_idle_acks"}, {r0_ack, r1_ack, r0_err, r1_err}, 0);
    chk({tag, "_idle_rdata"}, r0_rdata | r1_rdata, 0);
    chk({tag, "_idle_busy"}, busy, 0);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) sram[i] = {$urandom, $urandom, $urandom, $urandom};

    // Reset state.
    #1;
    chk_all_zero("reset");
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Single read from r1 at 0x41.
    sram[8'h41] = 128'hDEADBEEF_01234567_89ABCDEF_CAFEF00D;
    r1_req = 1'b1; r1_we = 1'b0; r1_addr = 8'h41;
    run_txn("single_read", 1, 0, 0);

    // Write from r0 to 0xFF, ack after three WAIT cycles.
    r0_req = 1'b1; r0_we = 1'b1; r0_addr = 8'hFF; r0_wdata = 128'h1;
    run_txn("write", 3, 0, 0);
    r1_req = 1'b1; r1_we = 1'b0; r1_addr = 8'hFF;
    run_txn("readback", 2, 0, 0);

    // Round-robin with both requesters held high.
    r0_req = 1'b1; r0_we = 1'b0; r0_addr = 8'h10;
    r1_req = 1'b1; r1_we = 1'b0; r1_addr = 8'h20;
    for (int i = 0; i < 4; i++) begin
      prev_ack = ack_cyc;
      run_txn("rr", 1, 1, 0);
      if (i > 0) chk("rr_spacing", 128'(ack_cyc - prev_ack), 3);
    end
    r0_req = 1'b0; r1_req = 1'b0;
    @(negedge clk);

    // Timeout, then mem_ack exactly in the last allowed cycle.
    r1_req = 1'b1; r1_we = 1'b0; r1_addr = 8'h33;
    run_txn("timeout", 0, 0, 0);
    r1_req = 1'b1;
    run_txn("late_ack", TO, 0, 0);

    // Enable gating.
    enable = 1'b0; r0_req = 1'b1; r0_we = 1'b0; r0_addr = 8'h05;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("gated_mem_req", mem_req, 0);
    end
    enable = 1'b1;
    run_txn("enable_rise", 1, 1, 1);
    for (int i = 0; i < 3; i++) begin
      chk("en_drop_no_grant", mem_req, 0);
      @(negedge clk);
    end
    enable = 1'b1;
    run_txn("enable_back", 2, 0, 0);

    // Reset mid-WAIT after r0 was last winner; r0 must still win the next tie.
    r0_req = 1'b1; r0_addr = 8'h07;
    run_txn("pre_reset", 1, 0, 0);
    r0_req = 1'b1;
    @(negedge clk);
    chk("pre_reset_wait", mem_req, 1);
    #2 rst = 1'b1;
    #1 chk_all_zero("mid_reset");
    @(negedge clk);
    rst = 1'b0;
    model_last = 1'b1;
    r0_req = 1'b1; r1_req = 1'b1;
    run_txn("post_reset_tie", 1, 0, 0);
    r0_req = 1'b0; r1_req = 1'b0;
    @(negedge clk);

    // Random transactions.
    for (int i = 0; i < 40; i++) begin
      int r;
      r        = $urandom_range(1, 3);
      r0_req   = r[0];
      r1_req   = r[1];
      r0_we    = 1'($urandom_range(0, 1));
      r1_we    = 1'($urandom_range(0, 1));
      r0_addr  = 8'($urandom_range(0, 7));
      r1_addr  = 8'($urandom_range(0, 7));
      r0_wdata = {$urandom, $urandom, $urandom, $urandom};
      r1_wdata = {$urandom, $urandom, $urandom, $urandom};
      run_txn("rand", $urandom_range(1, TO + 2), 0, 0);
      r0_req = 1'b0; r1_req = 1'b0;
      if ($urandom_range(0, 1) == 1) begin
        @(negedge clk);
        chk("rand_gap_idle", mem_req, 0);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/t05_codebook_sram_arbiter.md
# t05_codebook_sram_arbiter

Shares the single 128-bit codebook SRAM port between the codebook writer (requester 0, stores one path per char index) and the translation decoder (requester 1, reads paths by char index). One transaction is outstanding at a time. Ties are broken round-robin. A hung memory is caught by a timeout that returns an error acknowledge. The block sits between the decode-side requesters and the SRAM wrapper in the team_05 decompression path.

## Interface
Parameters:
- ADDR_W, 8: SRAM word address width (one word per char index, 256 entries)
- DATA_W, 128: path word width
- TIMEOUT, 255: maximum cycles mem_req stays high awaiting mem_ack; must be at least 1

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- enable  in  1  when low, no new grant is issued; an in-flight transaction still completes
- r0_req, r1_req  in  1  request; held high with fields stable until the matching ack
- r0_we, r1_we  in  1  1 = write, 0 = read
- r0_addr, r1_addr  in  ADDR_W  word address
- r0_wdata, r1_wdata  in  DATA_W  write data
- r0_ack, r1_ack  out  1  one-cycle completion pulse
- r0_err, r1_err  out  1  valid with ack; 1 = timeout
- r0_rdata, r1_rdata  out  DATA_W  read data; valid with ack
- mem_req  out  1  memory request
- mem_we  out  1  memory write enable
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_ack  in  1  memory completion; rdata valid in the same cycle
- mem_rdata  in  DATA_W  memory read data
- busy  out  1  high in WAIT and RESP
- grant_id  out  1  requester currently served; valid while busy

## Operation
State machine with three states: IDLE, WAIT and RESP.

- **IDLE**
  - If enable is high and any req is high, grant one requester.
  - If only one req is high, it is granted.
  - If both are high, grant the requester that is not last_grant.
  - On grant: register we/addr/wdata into mem_*, set grant_id, set last_grant to the winner, clear the timeout counter, go to WAIT.
- **WAIT**
  - mem_req = 1 and the mem_* fields are held constant.
  - If mem_ack is high: capture mem_rdata into the winner's rdata register, err = 0, go to RESP.
  - Otherwise increment the counter. When the counter reaches TIMEOUT without mem_ack: set rdata = 0, err = 1, go to RESP.
- **RESP**
  - mem_req = 0.
  - Pulse the winner's ack for one cycle; err and rdata are presented alongside it.
  - Go to IDLE.

Rules that apply across states:
- Register updates: the non-granted requester's ack, err and rdata stay 0. rdata and err return to 0 the cycle after ack.
- Requester protocol: drop req the cycle after observing ack. Because IDLE is entered only after RESP, a request held for one extra cycle is seen as a new request.
- Writes: rdata is unchanged from mem_rdata capture (don't-care to requester); err semantics are the same as for reads.
- Requests never preempt. A req change during WAIT or RESP is ignored until IDLE.
- mem_ack outside WAIT is ignored.
- Counter width is $clog2(TIMEOUT+1); it does not wrap.
- last_grant resets to 1, so r0 wins the first tie.

## Timing
- Reset (asynchronous, immediate): state IDLE. All outputs are 0, including mem_req, mem_we, mem_addr, mem_wdata, both acks, errs and rdatas, busy and grant_id. Counter 0, last_grant 1.
- Reset mid-transaction: the transaction is abandoned with no ack. mem_req drops immediately.
- Latency from req seen in IDLE (cycle 0):
  - mem_req is high from cycle 1.
  - If mem_ack arrives in cycle k ≥ 1, the ack pulse is in cycle k+1. Minimum latency is 2 cycles.
- Timeout with no mem_ack:
  - mem_req is high in cycles 1..TIMEOUT.
  - ack with err = 1 is in cycle TIMEOUT+1.
  - mem_ack in cycle TIMEOUT is still accepted as a normal completion.
- Back-to-back: the next grant can occur in the IDLE cycle following RESP. Peak throughput is one transaction per 3 cycles.
- enable falling during WAIT: the transaction finishes normally; no grant is made in the following IDLE.

## Test plan
- **Reset values:** assert rst mid-WAIT → all outputs 0 in the same cycle. After release with both req high, r0 is granted first.
- **Single read:** r1_req, we=0, addr=0x41; mem_ack one cycle after mem_req with rdata=0xDEADBEEF… → mem_addr=0x41 from cycle 1, r1_ack with that rdata in cycle 3, r1_err=0.
- **Round-robin under contention:** r0 and r1 both requesting continuously with immediate mem_ack → grants alternate 0,1,0,1 and each ack arrives 3 cycles apart.
- **Write path:** r0 write, addr=0xFF, wdata=128'h1 → mem_we=1, mem_addr=0xFF, mem_wdata=1 held until mem_ack; r0_ack asserted, r1_ack stays 0.
- **Timeout:** TIMEOUT=4, mem_ack never asserted → mem_req high for exactly 4 cycles, then r1_ack=1, r1_err=1, r1_rdata=0. Repeat with mem_ack in the 4th cycle → err=0.
- **Enable gating:** enable=0 with r0_req high → no mem_req for 10 cycles. Raise enable → grant in the next cycle.
